// File: rtl/ser_par_pkg.sv
// Shared types and constants for the serial link receiver (ser_par_rx).
package ser_par_pkg;

    localparam logic [7:0]  COMMA_DEFAULT = 8'hBC;
    localparam int unsigned BYTE_BITS     = 8;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       comma_det;
    } rx_out_t;

    function automatic logic is_comma(input logic [7:0] byte_v, input logic [7:0] comma_v);
        return (byte_v == comma_v);
    endfunction

endpackage

// File: rtl/ser_par_shift.sv
// Bit-level front end: serial history plus byte-phase counter.
// The candidate byte includes the bit being sampled this cycle, so it is combinational.
module ser_par_shift
    import ser_par_pkg::*;
(
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       data_in,
    input  logic       phase_rst,
    output logic [7:0] cand_byte,
    output logic       boundary
);

    // Only the seven most recent bits are needed to form the candidate with data_in.
    logic [6:0] shift_r;
    logic [2:0] bit_cnt_r;

    // Shift history and byte-phase counter; phase_rst re-anchors the byte grid.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            shift_r   <= 7'd0;
            bit_cnt_r <= 3'd0;
        end else begin
            shift_r <= {shift_r[5:0], data_in};
            if (phase_rst) begin
                bit_cnt_r <= 3'd0;
            end else begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
        end
    end

    assign cand_byte = {shift_r, data_in};
    assign boundary  = (bit_cnt_r == 3'(BYTE_BITS - 1));

endmodule

// File: rtl/ser_par_rx.sv
// Serial link receiver: comma alignment, lock acquisition and byte output.
// Optional macro SER_PAR_RX_REALIGN_EN: re-align on a misaligned comma while LOCKED.
module ser_par_rx
    import ser_par_pkg::*;
#(
    parameter logic [7:0]  COMMA       = COMMA_DEFAULT,
    parameter int unsigned COMMA_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       comma_det
);

    localparam logic [3:0] CNT_TARGET = 4'(COMMA_COUNT);

    rx_state_e  state_r;
    rx_state_e  state_nxt_s;
    logic [3:0] comma_cnt_r;
    logic [3:0] comma_cnt_nxt_s;
    logic       phase_rst_s;
    logic [7:0] cand_byte_s;
    logic       boundary_s;
    logic       cand_comma_s;
    rx_out_t    out_r;
    rx_out_t    out_nxt_s;
    logic       active_r;

    ser_par_shift u_shift (
        .clk_32f   (clk_32f),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .phase_rst (phase_rst_s),
        .cand_byte (cand_byte_s),
        .boundary  (boundary_s)
    );

    assign cand_comma_s = is_comma(cand_byte_s, COMMA);

    // State and comma counter registers.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state_r     <= SEARCH;
            comma_cnt_r <= 4'd0;
        end else begin
            state_r     <= state_nxt_s;
            comma_cnt_r <= comma_cnt_nxt_s;
        end
    end

    // Next-state logic: bit-level scan in SEARCH, byte-level checks once aligned.
    always_comb begin
        state_nxt_s     = state_r;
        comma_cnt_nxt_s = comma_cnt_r;
        phase_rst_s     = 1'b0;
        case (state_r)
            SEARCH: begin
                if (cand_comma_s) begin
                    phase_rst_s     = 1'b1;
                    comma_cnt_nxt_s = 4'd1;
                    if (CNT_TARGET == 4'd1) begin
                        state_nxt_s = LOCKED;
                    end else begin
                        state_nxt_s = ALIGN;
                    end
                end else begin
                    state_nxt_s = SEARCH;
                end
            end
            ALIGN: begin
                if (boundary_s) begin
                    if (cand_comma_s) begin
                        comma_cnt_nxt_s = comma_cnt_r + 4'd1;
                        if ((comma_cnt_r + 4'd1) == CNT_TARGET) begin
                            state_nxt_s = LOCKED;
                        end else begin
                            state_nxt_s = ALIGN;
                        end
                    end else begin
                        comma_cnt_nxt_s = 4'd0;
                        state_nxt_s     = SEARCH;
                    end
                end else begin
                    state_nxt_s = ALIGN;
                end
            end
            LOCKED: begin
`ifdef SER_PAR_RX_REALIGN_EN
                // A comma off the byte grid means the sender's phase moved: re-acquire.
                if (!boundary_s && cand_comma_s) begin
                    phase_rst_s     = 1'b1;
                    comma_cnt_nxt_s = 4'd1;
                    state_nxt_s     = ALIGN;
                end else begin
                    state_nxt_s = LOCKED;
                end
`else
                state_nxt_s = LOCKED;
`endif
            end
            default: begin
                state_nxt_s     = SEARCH;
                comma_cnt_nxt_s = 4'd0;
            end
        endcase
    end

    // Output decode at byte boundaries; data_out holds its value across commas.
    always_comb begin
        out_nxt_s.data      = out_r.data;
        out_nxt_s.valid     = 1'b0;
        out_nxt_s.comma_det = 1'b0;
        case (state_r)
            SEARCH: begin
                out_nxt_s.comma_det = 1'b0;
            end
            ALIGN: begin
                if (boundary_s && cand_comma_s) begin
                    out_nxt_s.comma_det = 1'b1;
                end else begin
                    out_nxt_s.comma_det = 1'b0;
                end
            end
            LOCKED: begin
                if (boundary_s) begin
                    if (cand_comma_s) begin
                        out_nxt_s.comma_det = 1'b1;
                    end else begin
                        out_nxt_s.data  = cand_byte_s;
                        out_nxt_s.valid = 1'b1;
                    end
                end else begin
                    out_nxt_s.valid = 1'b0;
                end
            end
            default: begin
                out_nxt_s.data = 8'h00;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            out_r    <= '0;
            active_r <= 1'b0;
        end else begin
            out_r    <= out_nxt_s;
            active_r <= (state_nxt_s == LOCKED);
        end
    end

    assign data_out  = out_r.data;
    assign valid_out = out_r.valid;
    assign comma_det = out_r.comma_det;
    assign active    = active_r;

endmodule

// File: tb/tb_ser_par_rx.sv
// Directed bench for ser_par_rx with a bit-stream reference model and literal spot checks.
module tb_ser_par_rx;

    logic       clk_32f = 1'b0;
    logic       reset_L = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       comma_det;

    always #5 clk_32f = ~clk_32f;

    ser_par_rx dut (
        .clk_32f   (clk_32f),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active),
        .comma_det (comma_det)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state: 0=searching, 1=aligning, 2=locked.
    int         m_state;
    int         m_idx;
    int         m_cnt;
    logic [7:0] m_win;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_cdet;

    int cyc = 0;
    int bits_since_rel;
    int last_valid_cyc;
    int prev_valid_cyc;
    int cdet_seen;
    int active_bit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_state = 0; m_idx = 0; m_cnt = 0;
        m_win = 8'h00; m_data = 8'h00; m_valid = 1'b0; m_cdet = 1'b0;
    endtask

    // One received bit: window of the last 8 bits, index of this bit within the byte grid.
    task automatic model_step(input logic b);
        logic [7:0] cand;
        int         nxt;
        logic       on_grid;
        cand    = {m_win[6:0], b};
        m_win   = cand;
        on_grid = ((m_idx % 8) == 7);
        nxt     = m_idx + 1;
        m_valid = 1'b0;
        m_cdet  = 1'b0;
        if (m_state == 0) begin
            if (cand == 8'hBC) begin
                nxt = 0; m_cnt = 1; m_state = 1;
            end
        end else if (m_state == 1) begin
            if (on_grid) begin
                if (cand == 8'hBC) begin
                    m_cnt++; m_cdet = 1'b1;
                    if (m_cnt == 4) m_state = 2;
                end else begin
                    m_cnt = 0; m_state = 0;
                end
            end
        end else begin
            if (on_grid) begin
                if (cand == 8'hBC) m_cdet = 1'b1;
                else begin m_data = cand; m_valid = 1'b1; end
            end
`ifdef SER_PAR_RX_REALIGN_EN
            else if (cand == 8'hBC) begin
                nxt = 0; m_cnt = 1; m_state = 1;
            end
`endif
        end
        m_idx = nxt;
    endtask

    task automatic compare_all();
        check("data_out", 32'(data_out), 32'(m_data));
        check("valid_out", 32'(valid_out), 32'(m_valid));
        check("active", 32'(active), 32'(m_state == 2));
        check("comma_det", 32'(comma_det), 32'(m_cdet));
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        data_in = b;
        @(posedge clk_32f);
        model_step(b);
        #1;
        compare_all();
        cyc++;
        bits_since_rel++;
        if (valid_out) begin
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
        end
        if (comma_det) cdet_seen++;
        if (active && active_bit < 0) active_bit = bits_since_rel;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_32f);
            reset_L = 1'b0;
            data_in = 1'($urandom_range(0, 1));
            @(posedge clk_32f);
            model_reset();
            #1;
            compare_all();
            cyc++;
        end
    endtask

    task automatic release_reset();
        reset_L        = 1'b1;
        bits_since_rel = 0;
        cdet_seen      = 0;
        active_bit     = -1;
    endtask

    initial begin
        model_reset();
        // 1: reset with random input, then four commas
        hold_reset(6);
        check("reset_outputs", {22'd0, data_out, valid_out, active, comma_det}, 32'd0);
        release_reset();
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        check("lock_bit_t1", 32'(active_bit), 32'd32);
        check("comma_pulses_t1", 32'(cdet_seen), 32'd3);

        // 2: data while locked
        send_byte(8'h7C);
        check("t2_valid_7c", 32'(valid_out), 32'd1);
        check("t2_data_7c", 32'(data_out), 32'h7C);
        send_byte(8'h55);
        check("t2_data_55", 32'(data_out), 32'h55);
        check("t2_valid_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'd8);
        send_byte(8'hBC);
        check("t2_comma_only", {30'd0, comma_det, valid_out}, 32'd2);
        check("t2_data_held", 32'(data_out), 32'h55);

        // 3: three-bit offset before the commas
        hold_reset(2);
        release_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        check("lock_bit_t3", 32'(active_bit), 32'd35);
        send_byte(8'h96);
        check("t3_data_96", 32'(data_out), 32'h96);

        // 4: alignment broken by a data byte, counter restarts
        hold_reset(2);
        release_reset();
        send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h00);
        check("t4_active_after_00", 32'(active), 32'd0);
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        check("t4_not_locked_3", 32'(active), 32'd0);
        send_byte(8'hBC);
        check("lock_bit_t4", 32'(active_bit), 32'd56);
        send_byte(8'hA5);
        check("t4_data_a5", 32'(data_out), 32'hA5);

        // 5: asynchronous reset mid-byte while locked
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        #2;
        reset_L = 1'b0;
        #1;
        check("t5_async_clear", {22'd0, data_out, valid_out, active, comma_det}, 32'd0);
        model_reset();
        hold_reset(2);
        release_reset();
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        check("t5_not_locked_3", 32'(active), 32'd0);
        send_byte(8'hBC);
        check("t5_relocked", 32'(active), 32'd1);

        // 6: one-bit slip while locked
        send_bit(1'b0);
        send_byte(8'hBC);
`ifdef SER_PAR_RX_REALIGN_EN
        check("t6_active_dropped", 32'(active), 32'd0);
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        check("t6_relocked", 32'(active), 32'd1);
        send_byte(8'h3C);
        check("t6_data_3c", 32'(data_out), 32'h3C);
`else
        check("t6_active_kept", 32'(active), 32'd1);
        check("t6_misframed", 32'(data_out), 32'h5E);
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        send_byte(8'h3C);
        check("t6_misframed_3c", 32'(data_out), 32'h1E);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
